// File: rtl/clk_div_ratio_monitor_if.sv
// Status/control bundle between the divided-clock monitor and its consumer (serializer start-up, status regs).
// Combinational wiring only; the monitor never waits on its consumer.
interface clk_div_ratio_monitor_if #(
    parameter int ERR_W = 8
);
    logic             en_i;
    logic             div_clk_i;
    logic             err_clr_i;
    logic             locked_o;
    logic             err_o;
    logic [7:0]       period_o;
    logic [ERR_W-1:0] err_cnt_o;

    modport master (
        output en_i, div_clk_i, err_clr_i,
        input  locked_o, err_o, period_o, err_cnt_o
    );

    modport slave (
        input  en_i, div_clk_i, err_clr_i,
        output locked_o, err_o, period_o, err_cnt_o
    );
endinterface

// File: rtl/clk_div_ratio_monitor.sv
// Checks that div_clk_i has an exact RATIO period and legal high time; locks after LOCK_COUNT good periods.
// Rise detected 2-3 clk_i after the div_clk_i edge, verdict registered 1 cycle later; no backpressure.
module clk_div_ratio_monitor #(
    parameter int RATIO      = 5,
    parameter int HIGH_MIN   = 2,
    parameter int HIGH_MAX   = 3,
    parameter int LOCK_COUNT = 16,
    parameter int ERR_W      = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    clk_div_ratio_monitor_if.slave  mon
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam int         STALL_I   = (2 * RATIO > 255) ? 255 : 2 * RATIO;
    localparam logic [7:0] RATIO_C   = 8'(RATIO);
    localparam logic [7:0] STALL_PRE = 8'(STALL_I - 1);
    localparam logic [7:0] HMIN_C    = 8'(HIGH_MIN);
    localparam logic [7:0] HMAX_C    = 8'(HIGH_MAX);
    localparam logic [7:0] LOCK_C    = 8'(LOCK_COUNT);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    if (!(HIGH_MIN <= HIGH_MAX && HIGH_MAX < RATIO && RATIO >= 3 && RATIO <= 255 &&
          LOCK_COUNT >= 1 && LOCK_COUNT <= 255)) begin : g_param_err
        $error("clk_div_ratio_monitor: illegal RATIO/HIGH_MIN/HIGH_MAX/LOCK_COUNT combination");
    end

    logic       sync1, sync2, prev;
    logic       rise;
    logic [7:0] per_cnt, hi_cnt, good_cnt, good_nxt;
    logic [1:0] state, state_nxt;
    logic       locked_nxt;
    logic       period_good, stall, checking, bad_evt, good_evt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= mon.div_clk_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    // Counter values seen on the rise cycle describe the period that just closed.
    assign period_good = (per_cnt == RATIO_C) && (hi_cnt >= HMIN_C) && (hi_cnt <= HMAX_C);
    // Fires only on the step into the stall threshold, so a held-low clock errors once.
    assign stall       = !rise && (per_cnt == STALL_PRE);
    assign checking    = mon.en_i && (state != ST_IDLE);
    assign bad_evt     = checking && ((rise && !period_good) || stall);
    assign good_evt    = checking && rise && period_good;

    always_comb begin
        state_nxt  = state;
        good_nxt   = good_cnt;
        locked_nxt = mon.locked_o;
        if (!mon.en_i) begin
            state_nxt  = ST_IDLE;
            good_nxt   = 8'd0;
            locked_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    good_nxt   = 8'd0;
                    locked_nxt = 1'b0;
                    if (rise) state_nxt = ST_TRACK;
                end
                ST_TRACK: begin
                    if (bad_evt) begin
                        good_nxt = 8'd0;
                    end else if (good_evt) begin
                        good_nxt = good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == LOCK_C) begin
                            state_nxt  = ST_LOCKED;
                            locked_nxt = 1'b1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (bad_evt) begin
                        state_nxt  = ST_TRACK;
                        good_nxt   = 8'd0;
                        locked_nxt = 1'b0;
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    good_nxt   = 8'd0;
                    locked_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            per_cnt       <= 8'd0;
            hi_cnt        <= 8'd0;
            good_cnt      <= 8'd0;
            state         <= ST_IDLE;
            mon.locked_o  <= 1'b0;
            mon.err_o     <= 1'b0;
            mon.period_o  <= 8'd0;
            mon.err_cnt_o <= '0;
        end else begin
            if (rise) begin
                per_cnt      <= 8'd1;
                hi_cnt       <= 8'd1;
                mon.period_o <= per_cnt;
            end else begin
                if (per_cnt != 8'hFF) per_cnt <= per_cnt + 8'd1;
                if (sync2 && hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;
            end
            state        <= state_nxt;
            good_cnt     <= good_nxt;
            mon.locked_o <= locked_nxt;
            mon.err_o    <= bad_evt;
            // Counting the registered pulse lets a clear issued alongside err_o win.
            if (mon.err_clr_i)
                mon.err_cnt_o <= '0;
            else if (mon.err_o && mon.err_cnt_o != ERR_MAX)
                mon.err_cnt_o <= mon.err_cnt_o + 1'b1;
        end
    end
endmodule
